addr_mem_unit: RTL and testbench

Parametrised second-generation address/memory block. Holds a bank of NREGS address registers with register 0 as the program counter, plus a DEPTH×DATA_W RAM. Address registers drive or load the shared address bus, and the RAM reads/writes the shared memory bus. Adds explicit per-register increment/decrement and optional write protection of a low ROM region.

---
 rtl/addr_mem_pkg.sv | 15 +
 rtl/addr_mem_unit_addr_reg.sv | 33 +++
 rtl/addr_mem_unit.sv | 121 ++++++++++++
 tb/tb_addr_mem_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_mem_pkg.sv
// Shared constants, control decode and index type for the address/memory unit.
package addr_mem_pkg;

    localparam logic [2:0] ADDR_SEL_NONE      = 3'd0;
    localparam logic [2:0] MEM_OUT_CODE_DFLT  = 3'd3;
    localparam logic [2:0] MEM_LOAD_CODE_DFLT = 3'd3;

    typedef logic [2:0] reg_idx_t;

    // Control nibble: bit 3 is an active-low enable, [2:0] must match the code.
    function automatic logic ctl_decode(input logic [3:0] i_ctl, input logic [2:0] i_code);
        return !i_ctl[3] && (i_ctl[2:0] == i_code);
    endfunction

endpackage

// File: rtl/addr_mem_unit_addr_reg.sv
// Single address register with async active-low reset; load beats inc/dec.
module addr_reg #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic [ADDR_W-1:0] i_d,
    output logic [ADDR_W-1:0] o_q
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_inc && !i_dec) begin
            r_q <= r_q + ONE;
        end else if (i_dec && !i_inc) begin
            r_q <= r_q - ONE;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/addr_mem_unit.sv
// Address register bank (reg 0 = PC) plus RAM on shared abus/mbus.
// Optional low-region write protection: define ADDR_MEM_ROM_PROTECT_EN.
module addr_mem_unit
    import addr_mem_pkg::*;
#(
    parameter int                ADDR_W        = 16,
    parameter int                DATA_W        = 8,
    parameter int                DEPTH         = 65536,
    parameter int                NREGS         = 4,
    parameter logic [ADDR_W-1:0] PC_RESET      = '0,
    parameter logic [2:0]        MEM_OUT_CODE  = MEM_OUT_CODE_DFLT,
    parameter logic [2:0]        MEM_LOAD_CODE = MEM_LOAD_CODE_DFLT,
    parameter logic [ADDR_W-1:0] ROM_TOP       = 'h0100
) (
    input  logic              clk,
    input  logic              rstn,
    inout  wire  [ADDR_W-1:0] abus,
    inout  wire  [DATA_W-1:0] mbus,
    input  logic [2:0]        addroutctl,
    input  logic [2:0]        addrloadctl,
    input  logic [NREGS-1:0]  incctl,
    input  logic [NREGS-1:0]  decctl,
    input  logic [3:0]        outctl,
    input  logic [3:0]        loadctl,
    output logic              ro_fault
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] w_reg_q [NREGS];
    logic [NREGS-1:0]  w_drive;
    logic [NREGS-1:0]  w_load;
    logic [ADDR_W-1:0] w_abus_val;
    logic              w_abus_en;
    logic [IDX_W-1:0]  w_idx;
    logic              w_rd_en;
    logic              w_wr_req;
    logic              w_wr_en;
    logic              w_unused_ok;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Codes above NREGS simply match no register.
    always_comb begin
        w_drive    = '0;
        w_load     = '0;
        w_abus_val = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (addroutctl == reg_idx_t'(k + 1)) begin
                w_drive[k] = 1'b1;
                w_abus_val = w_reg_q[k];
            end
            if (addrloadctl == reg_idx_t'(k + 1)) begin
                w_load[k] = 1'b1;
            end
        end
    end

    assign w_abus_en = rstn && (addroutctl != ADDR_SEL_NONE) && (w_drive != '0);
    assign abus      = w_abus_en ? w_abus_val : 'z;

    for (genvar k = 0; k < NREGS; k++) begin : g_reg
        if (k == 0) begin : g_pc
            addr_reg #(.ADDR_W(ADDR_W), .RESET_VAL(PC_RESET)) u_reg (
                .i_clk  (clk),
                .i_rstn (rstn),
                .i_load (w_load[0]),
                .i_inc  (w_drive[0]),
                .i_dec  (1'b0),
                .i_d    (abus),
                .o_q    (w_reg_q[0])
            );
        end else begin : g_gp
            addr_reg #(.ADDR_W(ADDR_W), .RESET_VAL('0)) u_reg (
                .i_clk  (clk),
                .i_rstn (rstn),
                .i_load (w_load[k]),
                .i_inc  (incctl[k]),
                .i_dec  (decctl[k]),
                .i_d    (abus),
                .o_q    (w_reg_q[k])
            );
        end
    end

    // High abus bits alias onto the same RAM word.
    assign w_idx    = abus[IDX_W-1:0];
    assign w_rd_en  = rstn && ctl_decode(outctl, MEM_OUT_CODE);
    assign w_wr_req = rstn && ctl_decode(loadctl, MEM_LOAD_CODE);
    assign mbus     = w_rd_en ? r_mem[w_idx] : 'z;

`ifdef ADDR_MEM_ROM_PROTECT_EN
    logic w_blocked;
    logic r_ro_fault;

    assign w_blocked = w_wr_req && (abus < ROM_TOP);
    assign w_wr_en   = w_wr_req && !w_blocked;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ro_fault <= 1'b0;
        end else begin
            r_ro_fault <= w_blocked;
        end
    end

    assign ro_fault    = r_ro_fault;
    assign w_unused_ok = incctl[0] ^ decctl[0];
`else
    assign w_wr_en     = w_wr_req;
    assign ro_fault    = 1'b0;
    assign w_unused_ok = incctl[0] ^ decctl[0] ^ (|ROM_TOP);
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= mbus;
        end
    end

endmodule

// File: tb/tb_addr_mem_unit.sv
// Self-checking bench for addr_mem_unit: spec-level model, directed plan, random traffic.
module tb_addr_mem_unit;

`ifdef ADDR_MEM_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    wire  [15:0] abus;
    wire  [7:0]  mbus;
    logic [2:0]  addroutctl;
    logic [2:0]  addrloadctl;
    logic [3:0]  incctl;
    logic [3:0]  decctl;
    logic [3:0]  outctl;
    logic [3:0]  loadctl;
    logic        ro_fault;

    logic [15:0] tb_abus;
    logic [7:0]  tb_mbus;
    bit          chk_on = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    logic [15:0] m_reg [4];
    logic [7:0]  m_mem [logic [15:0]];
    logic        m_fault;

    always #5 clk = ~clk;

    // The bench drives a bus only when the spec says the DUT must release it.
    wire exp_a_drv = rstn && (addroutctl >= 3'd1) && (addroutctl <= 3'd4);
    wire exp_m_drv = rstn && !outctl[3] && (outctl[2:0] == 3'd3);
    assign abus = exp_a_drv ? 'z : tb_abus;
    assign mbus = exp_m_drv ? 'z : tb_mbus;

    addr_mem_unit #(.PC_RESET(16'h0010)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .abus        (abus),
        .mbus        (mbus),
        .addroutctl  (addroutctl),
        .addrloadctl (addrloadctl),
        .incctl      (incctl),
        .decctl      (decctl),
        .outctl      (outctl),
        .loadctl     (loadctl),
        .ro_fault    (ro_fault)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what each edge must do to registers, RAM and ro_fault.
    logic [15:0] mdl_a;
    logic        mdl_wr, mdl_blk;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_reg[0] = 16'h0010;
            for (int k = 1; k < 4; k++) m_reg[k] = 16'h0000;
            m_fault = 1'b0;
        end else begin
            mdl_a   = exp_a_drv ? m_reg[addroutctl - 3'd1] : tb_abus;
            mdl_wr  = !loadctl[3] && (loadctl[2:0] == 3'd3);
            mdl_blk = PROT && mdl_wr && (mdl_a < 16'h0100);
            if (mdl_wr && !mdl_blk && !exp_m_drv) m_mem[mdl_a] = tb_mbus;
            m_fault = mdl_blk;
            for (int k = 0; k < 4; k++) begin
                if (addrloadctl == 3'(k + 1)) m_reg[k] = mdl_a;
                else if (k == 0) begin
                    if (addroutctl == 3'd1) m_reg[0] = m_reg[0] + 16'd1;
                end else if (incctl[k] && !decctl[k]) m_reg[k] = m_reg[k] + 16'd1;
                else if (decctl[k] && !incctl[k]) m_reg[k] = m_reg[k] - 16'd1;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    logic [15:0] cmp_a;
    always @(negedge clk) begin
        if (chk_on) begin
            cmp_a = exp_a_drv ? m_reg[addroutctl - 3'd1] : tb_abus;
            chk("abus", 32'(abus), 32'(cmp_a));
            if (!exp_m_drv) chk("mbus_hz", 32'(mbus), 32'(tb_mbus));
            else if (m_mem.exists(cmp_a)) chk("mbus_rd", 32'(mbus), 32'(m_mem[cmp_a]));
            chk("ro_fault", 32'(ro_fault), 32'(m_fault));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addroutctl  = 3'd0;
        addrloadctl = 3'd0;
        incctl      = 4'h0;
        decctl      = 4'h0;
        outctl      = 4'h8;
        loadctl     = 4'h8;
    endtask

    task automatic load_reg(input int k, input logic [15:0] v);
        idle();
        tb_abus     = v;
        addrloadctl = 3'(k + 1);
        cyc();
        idle();
    endtask

    logic [7:0] v_before;

    initial begin
        rstn = 1'b0;
        idle();
        tb_abus    = 16'h5A5A;
        tb_mbus    = 8'h3C;
        addroutctl = 3'd1;
        outctl     = 4'h3;
        loadctl    = 4'h3;
        chk_on     = 1'b1;
        repeat (3) cyc();
        rstn = 1'b1;
        idle();
        @(negedge clk);
        chk("rst_abus_hz", 32'(abus), 32'h5A5A);

        // PC drive and fetch-advance
        cyc();
        addroutctl = 3'd1;
        @(negedge clk);
        chk("pc_reset", 32'(abus), 32'h0010);
        repeat (3) cyc();
        @(negedge clk);
        chk("pc_adv3", 32'(abus), 32'h0013);

        // RAM write then read next cycle
        load_reg(1, 16'h0200);
        addroutctl = 3'd2;
        loadctl    = 4'h3;
        tb_mbus    = 8'hA5;
        cyc();
        loadctl = 4'h8;
        outctl  = 4'h3;
        @(negedge clk);
        chk("ram_wr_rd", 32'(mbus), 32'hA5);

        // Wrap-around and inc/dec cancellation
        load_reg(1, 16'hFFFF);
        incctl = 4'b0010;
        cyc();
        idle();
        addroutctl = 3'd2;
        @(negedge clk);
        chk("inc_wrap", 32'(abus), 32'h0000);
        load_reg(2, 16'h0000);
        decctl = 4'b0100;
        cyc();
        idle();
        addroutctl = 3'd3;
        @(negedge clk);
        chk("dec_wrap", 32'(abus), 32'hFFFF);
        cyc();
        incctl = 4'b0101;
        decctl = 4'b0101;
        cyc();
        idle();
        addroutctl = 3'd3;
        @(negedge clk);
        chk("incdec_both", 32'(abus), 32'hFFFF);

        // Load beats PC auto-increment; load PC from another register
        load_reg(0, 16'h0040);
        addroutctl  = 3'd1;
        addrloadctl = 3'd1;
        cyc();
        addrloadctl = 3'd0;
        @(negedge clk);
        chk("pc_load_pri", 32'(abus), 32'h0040);
        load_reg(1, 16'h1234);
        addroutctl  = 3'd2;
        addrloadctl = 3'd1;
        cyc();
        idle();
        addroutctl = 3'd1;
        @(negedge clk);
        chk("pc_load_ext", 32'(abus), 32'h1234);
        cyc();
        idle();
        addroutctl = 3'd7;
        tb_abus    = 16'h5555;
        @(negedge clk);
        chk("sel7_hz_a", 32'(abus), 32'h5555);
        tb_abus = 16'hAAAA;
        #2;
        chk("sel7_hz_b", 32'(abus), 32'hAAAA);

        // Low-region write
        load_reg(1, 16'h00FF);
        addroutctl = 3'd2;
        outctl     = 4'h3;
        @(negedge clk);
        v_before = mbus;
        cyc();
        outctl  = 4'h8;
        loadctl = 4'h3;
        tb_mbus = 8'h5A;
        cyc();
        loadctl = 4'h8;
        outctl  = 4'h3;
        @(negedge clk);
        chk("rom_fault_pulse", 32'(ro_fault), PROT ? 32'h1 : 32'h0);
        chk("rom_mem", 32'(mbus), PROT ? 32'(v_before) : 32'h5A);
        cyc();
        @(negedge clk);
        chk("rom_fault_clear", 32'(ro_fault), 32'h0);
        load_reg(1, 16'h0100);
        addroutctl = 3'd2;
        loadctl    = 4'h3;
        tb_mbus    = 8'hC3;
        cyc();
        loadctl = 4'h8;
        outctl  = 4'h3;
        @(negedge clk);
        chk("rom_top_wr", 32'(mbus), 32'hC3);
        chk("rom_top_nofault", 32'(ro_fault), 32'h0);

        // Asynchronous reset mid-cycle with PC driving and a write enabled
        load_reg(0, 16'h0300);
        addroutctl = 3'd1;
        loadctl    = 4'h3;
        tb_mbus    = 8'h77;
        tb_abus    = 16'h6B6B;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_abus_hz", 32'(abus), 32'h6B6B);
        chk("arst_fault", 32'(ro_fault), 32'h0);
        cyc();
        cyc();
        rstn = 1'b1;
        idle();
        addroutctl = 3'd1;
        @(negedge clk);
        chk("arst_pc", 32'(abus), 32'h0010);
        load_reg(1, 16'h0200);
        addroutctl = 3'd2;
        outctl     = 4'h3;
        @(negedge clk);
        chk("arst_ram_keep", 32'(mbus), 32'hA5);
        load_reg(1, 16'h0300);
        addroutctl = 3'd2;
        outctl     = 4'h3;
        @(negedge clk);
        chk("arst_ram_keep2", 32'(mbus), 32'h77);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cyc();
            addroutctl  = 3'($urandom_range(0, 7));
            addrloadctl = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            incctl      = 4'($urandom);
            decctl      = 4'($urandom);
            outctl      = ($urandom_range(0, 2) == 0) ? 4'h3 : 4'($urandom);
            loadctl     = ($urandom_range(0, 2) == 0) ? 4'h3 : 4'($urandom);
            tb_abus     = ($urandom_range(0, 1) == 0) ? 16'(16'h00F0 + $urandom_range(0, 31))
                                                       : 16'($urandom);
            tb_mbus     = 8'($urandom);
        end
        cyc();
        idle();
        @(negedge clk);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
